// File: rtl/run_control.sv
// Run/step/stop clock-enable controller for the core and cycle counter.
// Three raw pushbuttons are synchronised, debounced and edge-detected before driving the FSM.

module run_control_debounce #(
   parameter int DB_COUNT = 1000000,
   parameter int DB_WIDTH = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_COUNT - 1);

   logic                s1;
   logic                s2;
   logic                db;
   logic                db_d;
   logic [DB_WIDTH-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         db   <= 1'b0;
         db_d <= 1'b0;
         cnt  <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         db_d <= db;
         // any agreement with the current level restarts the stability window
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + DB_WIDTH'(1);
         end
      end
   end

   assign press = db & ~db_d;
endmodule

// state | meaning
// IDLE  | stopped, ce low, waiting for a run or step press
// RUN   | free-running, ce high unless halt
// STEP  | single ce cycle, then back to IDLE
// HALT  | core retired a halt; frozen until reset
module run_control #(
   parameter int DB_COUNT = 1000000,
   parameter int DB_WIDTH = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_run,
   input  logic btn_step,
   input  logic btn_stop,
   input  logic halt,
   output logic ce,
   output logic running,
   output logic halted
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   run_press;
   logic   step_press;
   logic   stop_press;

   run_control_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_run (
      .clock (clock),
      .reset (reset),
      .raw   (btn_run),
      .press (run_press)
   );

   run_control_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_step (
      .clock (clock),
      .reset (reset),
      .raw   (btn_step),
      .press (step_press)
   );

   run_control_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_stop (
      .clock (clock),
      .reset (reset),
      .raw   (btn_stop),
      .press (stop_press)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            // stop outranks step, which outranks run
            if (halt)            state_nxt = S_HALT;
            else if (stop_press) state_nxt = S_IDLE;
            else if (step_press) state_nxt = S_STEP;
            else if (run_press)  state_nxt = S_RUN;
         end
         S_RUN: begin
            if (halt)            state_nxt = S_HALT;
            else if (stop_press) state_nxt = S_IDLE;
         end
         S_STEP: begin
            if (halt) state_nxt = S_HALT;
            else      state_nxt = S_IDLE;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ce drops combinationally so the core never advances past a retired halt
   always_comb begin
      ce      = 1'b0;
      running = 1'b0;
      halted  = 1'b0;
      if ((state == S_RUN || state == S_STEP) && !halt) ce = 1'b1;
      if (state == S_RUN)  running = 1'b1;
      if (state == S_HALT) halted  = 1'b1;
   end
endmodule
